// File: rtl/mem_stage_access.sv
// MEM-stage data-memory access unit and MEM/WB pipeline register.
// Non-memory ops: 1 cycle. Loads/stores: 2 + BUSY cycles. stallM holds the upstream stages while a transaction is in flight.
module mem_stage_access #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        validM,
  input  logic [31:0] instrM,
  input  logic        regwriteM,
  input  logic        memtoregM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic [4:0]  writeregM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stallM,
  output logic        validW,
  output logic        regwriteW,
  output logic        memtoregW,
  output logic [31:0] readdataW,
  output logic [31:0] aluoutW,
  output logic [4:0]  writeregW,
  output logic [31:0] instrW,
  output logic        errorW
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rbuf;
  logic             err;
  logic             memop;
  logic             misaligned;

  assign memop      = validM & (memtoregM | memwriteM);
  assign misaligned = aluoutM[1:0] != 2'b00;

  // Gated by rst_n so the stall releases the instant reset is applied.
  assign stallM = rst_n & (((state == IDLE) & memop & ~misaligned) | (state == BUSY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rbuf       <= '0;
      err        <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      validW     <= 1'b0;
      regwriteW  <= 1'b0;
      memtoregW  <= 1'b0;
      readdataW  <= '0;
      aluoutW    <= '0;
      writeregW  <= '0;
      instrW     <= '0;
      errorW     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memop && !misaligned) begin
            dmem_addr  <= aluoutM;
            dmem_wdata <= writedataM;
            dmem_we    <= memwriteM;
            dmem_req   <= 1'b1;
            cnt        <= '0;
            state      <= BUSY;
            validW     <= 1'b0;
            regwriteW  <= 1'b0;
          end else begin
            // A memop reaching here is misaligned: retire it as an error with no write-back.
            validW    <= validM;
            regwriteW <= validM & regwriteM & ~memop;
            memtoregW <= memtoregM;
            aluoutW   <= aluoutM;
            writeregW <= writeregM;
            instrW    <= instrM;
            readdataW <= '0;
            errorW    <= memop;
          end
        end
        BUSY: begin
          validW    <= 1'b0;
          regwriteW <= 1'b0;
          cnt       <= cnt + 1'b1;
          if (dmem_ack) begin
            if (!dmem_we) rbuf <= dmem_rdata;
            err      <= 1'b0;
            dmem_req <= 1'b0;
            state    <= RESP;
          end else if (cnt == CNT_LAST) begin
            err      <= 1'b1;
            dmem_req <= 1'b0;
            state    <= RESP;
          end
        end
        RESP: begin
          validW    <= validM;
          regwriteW <= validM & regwriteM & ~err;
          memtoregW <= memtoregM;
          aluoutW   <= aluoutM;
          writeregW <= writeregM;
          instrW    <= instrM;
          readdataW <= (err || !memtoregM) ? 32'h0 : rbuf;
          errorW    <= err;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: pass-through, load/store latency, misalignment, timeout, reset, back-to-back.
module tb_mem_stage_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        validM;
  logic [31:0] instrM;
  logic        regwriteM;
  logic        memtoregM;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [4:0]  writeregM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stallM;
  logic        validW;
  logic        regwriteW;
  logic        memtoregW;
  logic [31:0] readdataW;
  logic [31:0] aluoutW;
  logic [4:0]  writeregW;
  logic [31:0] instrW;
  logic        errorW;

  int checks = 0;
  int errors = 0;
  int n;

  mem_stage_access #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .validM(validM), .instrM(instrM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .memwriteM(memwriteM), .aluoutM(aluoutM), .writedataM(writedataM), .writeregM(writeregM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stallM(stallM),
    .validW(validW), .regwriteW(regwriteW), .memtoregW(memtoregW), .readdataW(readdataW),
    .aluoutW(aluoutW), .writeregW(writeregW), .instrW(instrW), .errorW(errorW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] wr, input logic [31:0] ins);
    validM     = v;
    regwriteM  = rw;
    memtoregM  = m2r;
    memwriteM  = mw;
    aluoutM    = alu;
    writedataM = wd;
    writeregM  = wr;
    instrM     = ins;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    bubble();

    // Reset state
    #2;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_stall", stallM, 1'b0);
    chk("rst_validW", validW, 1'b0);
    chk("rst_errorW", errorW, 1'b0);
    chk("rst_aluoutW", aluoutW, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD passes through in one cycle
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 32'h00A62820);
    #1;
    chk("add_stall", stallM, 1'b0);
    tick();
    chk("add_validW", validW, 1'b1);
    chk("add_aluoutW", aluoutW, 32'h1234);
    chk("add_writeregW", writeregW, 5'd5);
    chk("add_regwriteW", regwriteW, 1'b1);
    chk("add_instrW", instrW, 32'h00A62820);
    chk("add_readdataW", readdataW, 32'h0);

    // Invalid slot carrying load flags: no stall, no write-back
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd3, 32'h0);
    #1;
    chk("inv_stall", stallM, 1'b0);
    tick();
    chk("inv_validW", validW, 1'b0);
    chk("inv_regwriteW", regwriteW, 1'b0);

    // LW 0x100, ack two cycles after the request
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd8, 32'h8C080100);
    #1;
    chk("lw_stall_c0", stallM, 1'b1);
    chk("lw_req_c0", dmem_req, 1'b0);
    tick();
    chk("lw_req_c1", dmem_req, 1'b1);
    chk("lw_we", dmem_we, 1'b0);
    chk("lw_addr", dmem_addr, 32'h100);
    chk("lw_stall_c1", stallM, 1'b1);
    chk("lw_bubble_validW", validW, 1'b0);
    tick();
    chk("lw_req_c2", dmem_req, 1'b1);
    chk("lw_stall_c2", stallM, 1'b1);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    chk("lw_req_resp", dmem_req, 1'b0);
    chk("lw_stall_resp", stallM, 1'b0);
    tick();
    chk("lw_validW", validW, 1'b1);
    chk("lw_readdataW", readdataW, 32'hDEADBEEF);
    chk("lw_memtoregW", memtoregW, 1'b1);
    chk("lw_regwriteW", regwriteW, 1'b1);
    chk("lw_errorW", errorW, 1'b0);
    chk("lw_writeregW", writeregW, 5'd8);
    bubble();

    // SW 0x200, ack in the first BUSY cycle
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 5'd0, 32'hAC090200);
    #1;
    chk("sw_stall_c0", stallM, 1'b1);
    tick();
    chk("sw_req", dmem_req, 1'b1);
    chk("sw_we", dmem_we, 1'b1);
    chk("sw_wdata", dmem_wdata, 32'hCAFEF00D);
    chk("sw_addr", dmem_addr, 32'h200);
    chk("sw_stall_c1", stallM, 1'b1);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h55555555;
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    chk("sw_stall_resp", stallM, 1'b0);
    chk("sw_req_resp", dmem_req, 1'b0);
    tick();
    chk("sw_validW", validW, 1'b1);
    chk("sw_readdataW", readdataW, 32'h0);
    chk("sw_regwriteW", regwriteW, 1'b0);
    chk("sw_memtoregW", memtoregW, 1'b0);
    chk("sw_errorW", errorW, 1'b0);
    bubble();

    // Misaligned LW: no request, error retired in one cycle
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd7, 32'h8C070102);
    #1;
    chk("mis_stall", stallM, 1'b0);
    tick();
    chk("mis_req", dmem_req, 1'b0);
    chk("mis_validW", validW, 1'b1);
    chk("mis_errorW", errorW, 1'b1);
    chk("mis_regwriteW", regwriteW, 1'b0);
    chk("mis_readdataW", readdataW, 32'h0);
    chk("mis_aluoutW", aluoutW, 32'h102);
    bubble();
    tick();
    chk("mis_clear_errorW", errorW, 1'b0);

    // LW with no ack: times out after 16 BUSY cycles
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd4, 32'h8C040300);
    tick();
    n = 0;
    while (dmem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, 16);
    chk("to_stall_resp", stallM, 1'b0);
    tick();
    chk("to_validW", validW, 1'b1);
    chk("to_errorW", errorW, 1'b1);
    chk("to_readdataW", readdataW, 32'h0);
    chk("to_regwriteW", regwriteW, 1'b0);
    bubble();
    // Stray ack while idle must be ignored
    dmem_ack = 1'b1;
    dmem_rdata = 32'h99999999;
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    chk("stray_ack_req", dmem_req, 1'b0);
    chk("stray_ack_stall", stallM, 1'b0);
    chk("idle_validW", validW, 1'b0);

    // Reset in the middle of BUSY
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd6, 32'h8C060400);
    tick();
    chk("rb_req_before", dmem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_req", dmem_req, 1'b0);
    chk("rb_stall", stallM, 1'b0);
    chk("rb_validW", validW, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h5678, 32'h0, 5'd12, 32'h01AC6020);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rb_add_stall", stallM, 1'b0);
    tick();
    chk("rb_add_validW", validW, 1'b1);
    chk("rb_add_aluoutW", aluoutW, 32'h5678);
    chk("rb_add_writeregW", writeregW, 5'd12);

    // Back-to-back LW/LW
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 5'd9, 32'h8C090500);
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h11111111;
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    tick();
    chk("bb1_readdataW", readdataW, 32'h11111111);
    chk("bb1_writeregW", writeregW, 5'd9);
    chk("bb1_validW", validW, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h504, 32'h0, 5'd10, 32'h8C0A0504);
    #1;
    chk("bb2_stall_c0", stallM, 1'b1);
    tick();
    chk("bb2_addr", dmem_addr, 32'h504);
    chk("bb2_req", dmem_req, 1'b1);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h22222222;
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    tick();
    chk("bb2_readdataW", readdataW, 32'h22222222);
    chk("bb2_writeregW", writeregW, 5'd10);
    chk("bb2_errorW", errorW, 1'b0);
    bubble();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
